// File: rtl/user_input_pkg.sv
// Shared types and helpers for the push-button / DIP-switch reader.
// Event type codes match the consumer's decode of evt_data_o[top:top-1].
package user_input_pkg;

  typedef enum logic [1:0] {
    EVT_RELEASE = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_LONG    = 2'b10
  } evt_type_e;

  // Debounce counter holds up to 255 ms; the hold counter saturates at 65535 ms.
  localparam int unsigned DB_CNT_W = 8;
  localparam int unsigned HOLD_W   = 16;

  // Clock cycles per 1 ms tick for an integer MHz system clock.
  function automatic int unsigned TICK_DIV(input int unsigned mhz);
    return mhz * 1000;
  endfunction

endpackage

// File: rtl/user_input_reader_debounce.sv
// debounce_cell: 2-flop synchroniser, polarity fold, tick-based debouncer and press/release pulses.
// With USER_IN_LONG_PRESS_EN defined it also carries a saturating hold counter driving long_o.
module debounce_cell
  import user_input_pkg::*;
#(
  parameter logic        IN_POLARITY = 1'b0,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic raw_i,
  input  logic tick_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_MS - 1);

  logic                sync1_q, sync2_q;
  logic                sample;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                press_q, press_d;
  logic                release_q, release_d;

  // Synchroniser resets to the inactive pin level so reset release never looks like an edge.
  assign sample = sync2_q ^ ~IN_POLARITY;

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick_i) begin
      if (sample == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        level_d   = ~level_q;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q   <= ~IN_POLARITY;
      sync2_q   <= ~IN_POLARITY;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef USER_IN_LONG_PRESS_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  // A release tick never also fires LONG, so one serialiser slot per input per tick suffices.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!level_q) begin
      hold_d = '0;
    end else if (tick_i && !release_d) begin
      long_d = (hold_q == HOLD_LAST);
      if (hold_q != '1) hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  // No hold counter in this build, so LONG_MS has no effect.
  assign long_o = 1'b0 & (LONG_MS == 0);
`endif

endmodule

// File: rtl/user_input_reader.sv
// Board input reader: 1 ms prescaler, one debounce_cell per pin, pending-event serialiser and event FIFO.
// Optional macro USER_IN_LONG_PRESS_EN adds LONG events; port list and event width are the same either way.
module user_input_reader
  import user_input_pkg::*;
#(
  parameter  int unsigned CLK_IN_MHZ  = 12,
  parameter  int unsigned N_IN        = 8,
  parameter  logic        IN_POLARITY = 1'b0,
  parameter  int unsigned DEBOUNCE_MS = 10,
  parameter  int unsigned LONG_MS     = 1000,
  parameter  int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned IDX_W       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N_IN-1:0]  in_raw_i,
  output logic [N_IN-1:0]  in_level_o,
  output logic [N_IN-1:0]  in_press_o,
  output logic [N_IN-1:0]  in_release_o,
  output logic             evt_valid_o,
  output logic [IDX_W+1:0] evt_data_o,
  input  logic             evt_ready_i,
  output logic             evt_ovf_o
);

  localparam int unsigned           DIV        = TICK_DIV(CLK_IN_MHZ);
  localparam int unsigned           PRESC_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(DIV - 1);
  localparam int unsigned           AW         = $clog2(FIFO_DEPTH);

  typedef struct packed {
    evt_type_e        typ;
    logic [IDX_W-1:0] idx;
  } evt_t;

  // ---------------- 1 ms tick ----------------
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;

  always_comb begin
    tick_d  = (presc_q == PRESC_LAST);
    presc_d = tick_d ? '0 : presc_q + 1'b1;
  end

  // ---------------- per-input debouncers ----------------
  logic [N_IN-1:0] long_pulse;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_cell
    debounce_cell #(
      .IN_POLARITY (IN_POLARITY),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
    ) u_cell (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .raw_i     (in_raw_i[gi]),
      .tick_i    (tick_q),
      .level_o   (in_level_o[gi]),
      .press_o   (in_press_o[gi]),
      .release_o (in_release_o[gi]),
      .long_o    (long_pulse[gi])
    );
  end

  // ---------------- serialiser ----------------
  logic [N_IN-1:0]       pend_q, pend_d;
  logic [N_IN-1:0][1:0]  pend_type_q, pend_type_d;
  logic [N_IN-1:0]       pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  push;
  evt_t                  push_evt;

  // Descending scan so the lowest pending index wins.
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end

  assign push         = |pend_q;
  assign push_evt.typ = evt_type_e'(pend_type_q[pick_idx]);
  assign push_evt.idx = pick_idx;

  always_comb begin
    pend_d      = pend_q & ~pick_oh;
    pend_type_d = pend_type_q;
    for (int i = 0; i < N_IN; i++) begin
      if (in_press_o[i]) begin
        pend_d[i]      = 1'b1;
        pend_type_d[i] = EVT_PRESS;
      end else if (in_release_o[i]) begin
        pend_d[i]      = 1'b1;
        pend_type_d[i] = EVT_RELEASE;
      end else if (long_pulse[i]) begin
        pend_d[i]      = 1'b1;
        pend_type_d[i] = EVT_LONG;
      end
    end
  end

  // ---------------- event FIFO ----------------
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        ovf_q, ovf_d;
  logic        full, empty, pop, wr_en;
  evt_t        mem_q [FIFO_DEPTH];

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && evt_ready_i;
  assign wr_en = push && (!full || pop);

  always_comb begin
    wr_d  = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d  = pop   ? rd_q + 1'b1 : rd_q;
    ovf_d = ovf_q | (push && full && !pop);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= push_evt;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q     <= '0;
      tick_q      <= 1'b0;
      pend_q      <= '0;
      pend_type_q <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      ovf_q       <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      pend_q      <= pend_d;
      pend_type_q <= pend_type_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_valid_o = !empty;
  assign evt_data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign evt_ovf_o   = ovf_q;

endmodule

// File: tb/tb_user_input_reader.sv
// Randomised self-checking bench for user_input_reader against a per-millisecond behavioural model.
// Honours USER_IN_LONG_PRESS_EN when the same macro is defined for the build.
`timescale 1ns/1ps
module tb_user_input_reader;

  localparam int DIV   = 2000;
  localparam int MID   = 1000;
  localparam int DB    = 3;
  localparam int LONG  = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] raw = 4'hF;
  logic [3:0] level, press, rel;
  logic       valid, ovf;
  logic [3:0] data;
  logic       ready = 1'b0;

  always #5 clk = ~clk;

  user_input_reader #(
    .CLK_IN_MHZ (2),
    .N_IN       (4),
    .IN_POLARITY(1'b0),
    .DEBOUNCE_MS(DB),
    .LONG_MS    (LONG),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .in_raw_i    (raw),
    .in_level_o  (level),
    .in_press_o  (press),
    .in_release_o(rel),
    .evt_valid_o (valid),
    .evt_data_o  (data),
    .evt_ready_i (ready),
    .evt_ovf_o   (ovf)
  );

  // Clock edges since reset release; ticks land between consecutive mid-points.
  int unsigned cyc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int unsigned press_seen = 0, rel_seen = 0;
  always @(negedge clk) begin
    press_seen <= press_seen + $countones(press);
    rel_seen   <= rel_seen + $countones(rel);
  end

  // Behavioural model state
  logic [3:0] m_lvl;
  int         m_cnt[4];
  int         m_hold[4];
  int         m_q[$];
  logic       m_ovf;
  int         m_press, m_rel;
  int         long1_seen;

  int n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0;
    m_ovf = 1'b0;
    m_q.delete();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_hold[i] = 0;
    end
  endtask

  // One millisecond of the reference: pins are stable over the whole tick.
  task automatic model_tick(input logic [3:0] act);
    for (int i = 0; i < 4; i++) begin
      int   ev;
      logic old;
      logic releasing;
      ev        = -1;
      old       = m_lvl[i];
      releasing = 1'b0;
      if (act[i] != m_lvl[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == DB) begin
          m_cnt[i] = 0;
          m_lvl[i] = ~old;
          releasing = old;
          ev = old ? 0 : 1;
          if (old) m_rel++;
          else     m_press++;
        end
      end else begin
        m_cnt[i] = 0;
      end
`ifdef USER_IN_LONG_PRESS_EN
      if (old && !releasing) begin
        m_hold[i]++;
        if (m_hold[i] == LONG) ev = 2;
      end else begin
        m_hold[i] = 0;
      end
`endif
      if (ev >= 0) begin
        if (m_q.size() < DEPTH) m_q.push_back(ev * 4 + i);
        else                    m_ovf = 1'b1;
      end
    end
  endtask

  task automatic sync_mid();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while ((cyc % DIV) != MID && budget < 3 * DIV);
    if (budget >= 3 * DIV) check_eq("mid_timeout", budget, 0);
  endtask

  task automatic drain_all();
    int n;
    n = m_q.size();
    for (int k = 0; k < n; k++) begin
      check_eq("evt_valid", valid, 1);
      check_eq("evt_data", data, m_q[0]);
      if (data == 4'b1001) long1_seen++;
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      void'(m_q.pop_front());
    end
  endtask

  task automatic window(input logic [3:0] act, input bit drain);
    raw = ~act;
    sync_mid();
    model_tick(act);
    check_eq("level", level, m_lvl);
    check_eq("ovf", ovf, m_ovf);
    check_eq("press_pulses", press_seen, m_press);
    check_eq("release_pulses", rel_seen, m_rel);
    if (drain) drain_all();
    check_eq("valid", valid, (m_q.size() != 0) ? 1 : 0);
    if (m_q.size() != 0) check_eq("head", data, m_q[0]);
    else                 check_eq("idle_data", data, 0);
    $display("window act=%b drain=%0d level=%b queued=%0d ovf=%0d", act, drain, level, m_q.size(), ovf);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_level"}, level, 0);
    check_eq({tag, "_press"}, press, 0);
    check_eq({tag, "_release"}, rel, 0);
    check_eq({tag, "_valid"}, valid, 0);
    check_eq({tag, "_data"}, data, 0);
    check_eq({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    logic [3:0] act;
    m_press = 0;
    m_rel = 0;
    long1_seen = 0;
    model_reset();

    repeat (5) @(negedge clk);
    check_reset_outputs("rst");
    rstn = 1'b1;
    sync_mid();

    // Pin 2 press with pin 0 glitching active for two ticks only
    window(4'b0101, 0);
    window(4'b0101, 0);
    window(4'b0100, 1);

    // Pins 0,1,3 pressed together; head held with ready low, then drained in order
    window(4'b1111, 0);
    window(4'b1111, 0);
    window(4'b1111, 0);
    window(4'b1111, 1);

    // Four releases fill the FIFO, a fifth change overflows
    window(4'b0000, 0);
    window(4'b0000, 0);
    window(4'b0000, 0);
    window(4'b1000, 0);
    window(4'b1000, 0);
    window(4'b1000, 0);
    window(4'b1000, 1);

    // Reset mid-debounce with pins 0,1 at count 2
    window(4'b1011, 0);
    window(4'b1011, 0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    sync_mid();

    // Pins held through reset press after a full debounce; pin 1 then held ~15 ms with random neighbours
    window(4'b1011, 0);
    window(4'b1011, 0);
    window(4'b1011, 1);
    for (int w = 3; w < 20; w++) begin
      act    = 4'($urandom_range(0, 15));
      act[1] = (w < 17);
      window(act, 1);
    end
    window(4'b0000, 1);

`ifdef USER_IN_LONG_PRESS_EN
    check_eq("long_pin1", long1_seen, 1);
`else
    check_eq("long_pin1", long1_seen, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
